alu_sequencer: RTL and testbench

//  Control-side driver of the CPU ALU. Accepts one decoded ALU-class opcode per handshake and fetches its operand (register, d8 or (HL)).

---
 rtl/alu_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: control-side driver for the 8-bit ALU.
// Takes one decoded ALU-class opcode per handshake and fetches its operand from a register,
// the immediate byte or (HL). It then steers the ALU and commits the result to A, the register
// file or (HL). Flags are always committed in the EXEC cycle.
module alu_sequencer (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Instr_Valid,
    input  logic       i_Cb,
    input  logic [7:0] i_Opcode,
    output logic       o_Instr_Ready,
    output logic       o_Done,
    output logic       o_Illegal,
    output logic [2:0] o_Reg_Sel,
    input  logic [7:0] i_Reg_Data,
    output logic       o_Reg_We,
    output logic [7:0] o_Reg_Wdata,
    output logic       o_Mem_Req,
    output logic       o_Mem_We,
    output logic       o_Mem_Addr_Sel,
    output logic [7:0] o_Mem_Wdata,
    input  logic       i_Mem_Ack,
    input  logic [7:0] i_Mem_Rdata,
    output logic [1:0] o_Alu_Read,
    output logic [1:0] o_Alu_Write,
    output logic [7:0] o_Alu_Data,
    output logic [7:0] o_Alu_Opcode,
    output logic [7:0] o_Alu_Parameter,
    output logic [5:0] o_Alu_Function_Control,
    output logic       o_Alu_Save_Flags,
    input  logic [7:0] i_Alu_Result,
    input  logic [7:0] i_Alu_Reg_Data
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StWbMem} state_e;

    // Register index encoding: B,C,D,E,H,L,(HL),A = 0..7
    localparam logic [2:0] IdxHl = 3'd6;
    localparam logic [2:0] IdxA  = 3'd7;

    // Function-control encodings
    localparam logic [5:0] FcMain  = 6'b000001;
    localparam logic [5:0] FcRotA  = 6'b011000;
    localparam logic [5:0] FcMisc  = 6'b100000;
    localparam logic [5:0] FcCb    = 6'b001000;

    typedef struct packed {
        logic       legal;
        logic [5:0] fc;
        logic       src_d8;   // operand is the immediate byte at PC
        logic [2:0] src;      // operand register index when not src_d8
        logic       wr;       // result is written back (clear for CP / BIT)
        logic [2:0] dst;      // destination register index
    } dec_t;

    // Classify an opcode into operand source, destination and ALU unit
    function automatic dec_t decode(input logic cb, input logic [7:0] op);
        dec_t d;
        d = '0;
        if (cb) begin
            d.legal = 1'b1;
            d.fc    = FcCb;
            d.src   = op[2:0];
            d.dst   = op[2:0];
            d.wr    = (op[7:6] != 2'b01);
        end else begin
            case (op[7:6])
                2'b10: begin
                    d.legal = 1'b1;
                    d.fc    = FcMain;
                    d.src   = op[2:0];
                    d.dst   = IdxA;
                    d.wr    = (op[5:3] != 3'b111);
                end
                2'b11: begin
                    if (op[2:0] == 3'b110) begin
                        d.legal  = 1'b1;
                        d.fc     = FcMain;
                        d.src_d8 = 1'b1;
                        d.dst    = IdxA;
                        d.wr     = (op[5:3] != 3'b111);
                    end
                end
                2'b00: begin
                    if (op[2:1] == 2'b10) begin
                        d.legal = 1'b1;
                        d.fc    = {3'b000, op[0], 2'b10};
                        d.src   = op[5:3];
                        d.dst   = op[5:3];
                        d.wr    = 1'b1;
                    end else if (op[2:0] == 3'b111) begin
                        d.legal = 1'b1;
                        d.fc    = op[5] ? FcMisc : FcRotA;
                        d.src   = IdxA;
                        d.dst   = IdxA;
                        d.wr    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        return d;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic       cb_q, cb_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] result_q, result_d;

    dec_t       dec;
    logic       mem_src;

    // In IDLE the offered opcode is decoded; afterwards the latched one
    assign dec     = (state_q == StIdle) ? decode(i_Cb, i_Opcode) : decode(cb_q, opcode_q);
    assign mem_src = dec.src_d8 | (dec.src == IdxHl);

    // State and operand/result latches; everything freezes while i_Enable is low
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= StIdle;
            opcode_q  <= 8'h00;
            cb_q      <= 1'b0;
            operand_q <= 8'h00;
            result_q  <= 8'h00;
        end else if (i_Enable) begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cb_q      <= cb_d;
            operand_q <= operand_d;
            result_q  <= result_d;
        end
    end

    // Next-state and all control outputs
    always_comb begin
        state_d                = state_q;
        opcode_d               = opcode_q;
        cb_d                   = cb_q;
        operand_d              = operand_q;
        result_d               = result_q;
        o_Instr_Ready          = 1'b0;
        o_Done                 = 1'b0;
        o_Illegal              = 1'b0;
        o_Reg_Sel              = 3'd0;
        o_Reg_We               = 1'b0;
        o_Reg_Wdata            = 8'h00;
        o_Mem_Req              = 1'b0;
        o_Mem_We               = 1'b0;
        o_Mem_Addr_Sel         = 1'b0;
        o_Mem_Wdata            = 8'h00;
        o_Alu_Read             = 2'b00;
        o_Alu_Write            = 2'b00;
        o_Alu_Data             = 8'h00;
        o_Alu_Opcode           = 8'h00;
        o_Alu_Parameter        = 8'h00;
        o_Alu_Function_Control = 6'b000000;
        o_Alu_Save_Flags       = 1'b0;

        case (state_q)
            StIdle: begin
                o_Instr_Ready = 1'b1;
                if (i_Instr_Valid && i_Enable) begin
                    if (!dec.legal) begin
                        // Dropped with no side effects
                        o_Illegal = 1'b1;
                    end else begin
                        opcode_d = i_Opcode;
                        cb_d     = i_Cb;
                        state_d  = mem_src ? StFetch : StExec;
                    end
                end
            end

            StFetch: begin
                // Immediate comes from PC (advanced externally), otherwise from HL
                o_Mem_Req      = 1'b1;
                o_Mem_Addr_Sel = ~dec.src_d8;
                if (i_Mem_Ack) begin
                    operand_d = i_Mem_Rdata;
                    state_d   = StExec;
                end
            end

            StExec: begin
                o_Alu_Opcode           = opcode_q;
                o_Alu_Function_Control = dec.fc;
                o_Alu_Save_Flags       = 1'b1;
                o_Reg_Sel              = dec.src_d8 ? 3'd0 : dec.src;
                if (mem_src) begin
                    o_Alu_Parameter = operand_q;
                end else if (dec.src == IdxA) begin
                    o_Alu_Read      = 2'b01;
                    o_Alu_Parameter = i_Alu_Reg_Data;
                end else begin
                    o_Alu_Parameter = i_Reg_Data;
                end

                if (dec.wr && (dec.dst == IdxHl)) begin
                    result_d = i_Alu_Result;
                    state_d  = StWbMem;
                end else begin
                    o_Done  = 1'b1;
                    state_d = StIdle;
                    if (dec.wr) begin
                        if (dec.dst == IdxA) begin
                            o_Alu_Write = 2'b01;
                            o_Alu_Data  = i_Alu_Result;
                        end else begin
                            o_Reg_We    = 1'b1;
                            o_Reg_Wdata = i_Alu_Result;
                        end
                    end
                end
            end

            StWbMem: begin
                o_Mem_Req      = 1'b1;
                o_Mem_We       = 1'b1;
                o_Mem_Addr_Sel = 1'b1;
                o_Mem_Wdata    = result_q;
                if (i_Mem_Ack) begin
                    o_Done  = i_Enable;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models A/F, the register file, memory and a behavioural ALU, and
// checks each instruction against a reference computed from the opcode rules.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Reset, i_Enable, i_Instr_Valid, i_Cb, i_Mem_Ack;
    logic [7:0] i_Opcode, i_Reg_Data, i_Mem_Rdata, i_Alu_Result, i_Alu_Reg_Data;
    logic       o_Instr_Ready, o_Done, o_Illegal, o_Reg_We, o_Mem_Req, o_Mem_We, o_Mem_Addr_Sel;
    logic       o_Alu_Save_Flags;
    logic [2:0] o_Reg_Sel;
    logic [7:0] o_Reg_Wdata, o_Mem_Wdata, o_Alu_Data, o_Alu_Opcode, o_Alu_Parameter;
    logic [1:0] o_Alu_Read, o_Alu_Write;
    logic [5:0] o_Alu_Function_Control;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 i_Clk = ~i_Clk;

    alu_sequencer dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
        .i_Instr_Valid(i_Instr_Valid), .i_Cb(i_Cb), .i_Opcode(i_Opcode),
        .o_Instr_Ready(o_Instr_Ready), .o_Done(o_Done), .o_Illegal(o_Illegal),
        .o_Reg_Sel(o_Reg_Sel), .i_Reg_Data(i_Reg_Data), .o_Reg_We(o_Reg_We),
        .o_Reg_Wdata(o_Reg_Wdata), .o_Mem_Req(o_Mem_Req), .o_Mem_We(o_Mem_We),
        .o_Mem_Addr_Sel(o_Mem_Addr_Sel), .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Ack(i_Mem_Ack),
        .i_Mem_Rdata(i_Mem_Rdata), .o_Alu_Read(o_Alu_Read), .o_Alu_Write(o_Alu_Write),
        .o_Alu_Data(o_Alu_Data), .o_Alu_Opcode(o_Alu_Opcode),
        .o_Alu_Parameter(o_Alu_Parameter), .o_Alu_Function_Control(o_Alu_Function_Control),
        .o_Alu_Save_Flags(o_Alu_Save_Flags), .i_Alu_Result(i_Alu_Result),
        .i_Alu_Reg_Data(i_Alu_Reg_Data)
    );

    // Behavioural ALU: returns {result, flags}; flags are Z N H C in bits 7..4
    function automatic logic [15:0] alu_calc(input logic [5:0] fc, input logic [7:0] op,
                                             input logic [7:0] a, input logic [7:0] p,
                                             input logic [7:0] f);
        logic [8:0] t;
        logic [7:0] r;
        logic       z, n, h, c, ci;
        r = p; z = f[7]; n = f[6]; h = f[5]; c = f[4];
        if (fc[0]) begin
            ci = (op[5:3] == 3'd1 || op[5:3] == 3'd3) ? f[4] : 1'b0;
            n = 1'b0; h = 1'b0;
            case (op[5:3])
                3'd0, 3'd1: begin
                    t = {1'b0, a} + {1'b0, p} + {8'h00, ci};
                    h = ({1'b0, a[3:0]} + {1'b0, p[3:0]} + {4'h0, ci}) > 5'h0F;
                    r = t[7:0]; c = t[8];
                end
                3'd4: begin r = a & p; h = 1'b1; c = 1'b0; end
                3'd5: begin r = a ^ p; c = 1'b0; end
                3'd6: begin r = a | p; c = 1'b0; end
                default: begin
                    t = {1'b0, a} - {1'b0, p} - {8'h00, ci};
                    h = {1'b0, a[3:0]} < ({1'b0, p[3:0]} + {4'h0, ci});
                    r = t[7:0]; c = t[8]; n = 1'b1;
                end
            endcase
            z = (r == 8'h00);
        end else if (fc[1]) begin
            if (fc[2]) begin r = p - 8'h01; n = 1'b1; h = (p[3:0] == 4'h0); end
            else begin r = p + 8'h01; n = 1'b0; h = (p[3:0] == 4'hF); end
            z = (r == 8'h00);
        end else if (fc == 6'b001000) begin
            case (op[7:6])
                2'b01: begin z = ~p[op[5:3]]; n = 1'b0; h = 1'b1; end
                2'b10: r = p & ~(8'h01 << op[5:3]);
                2'b11: r = p | (8'h01 << op[5:3]);
                default: begin r = {p[6:0], p[7]}; z = (r == 8'h00); n = 1'b0; h = 1'b0;
                         c = p[7]; end
            endcase
        end else begin
            r = p ^ 8'hA5; c = ~f[4];
        end
        return {r, z, n, h, c, 4'h0};
    endfunction

    // Opcode rules: src 0..7 register index (6 = (HL), 7 = A), 8 = immediate; dst -1 = flags only
    function automatic void classify(input bit cb, input logic [7:0] op, output bit legal,
                                     output logic [5:0] fc, output int src, output int dst);
        legal = 1'b1; fc = 6'd0; src = 0; dst = -1;
        if (cb) begin
            fc = 6'b001000; src = int'(op[2:0]);
            dst = (op[7:6] == 2'b01) ? -1 : int'(op[2:0]);
        end else begin
            casez (op)
                8'b10??????: begin fc = 6'b000001; src = int'(op[2:0]);
                                   dst = (op[5:3] == 3'b111) ? -1 : 7; end
                8'b11???110: begin fc = 6'b000001; src = 8;
                                   dst = (op[5:3] == 3'b111) ? -1 : 7; end
                8'b00???10?: begin fc = {3'b000, op[0], 2'b10}; src = int'(op[5:3]);
                                   dst = int'(op[5:3]); end
                8'b000??111: begin fc = 6'b011000; src = 7; dst = 7; end
                8'b001??111: begin fc = 6'b100000; src = 7; dst = 7; end
                default: legal = 1'b0;
            endcase
        end
    endfunction

    // Environment: A, F, register file, (HL) byte and immediate byte
    logic [7:0] env_a, env_f, env_mem, env_d8;
    logic [7:0] env_rf [8];
    int         wr_cnt;
    logic       ld = 1'b0;
    logic [7:0] ld_a, ld_f, ld_mem, ld_d8;
    logic [7:0] ld_rf [8];
    logic [7:0] alu_res_c, alu_flg_c;

    assign i_Reg_Data     = env_rf[o_Reg_Sel];
    assign i_Alu_Reg_Data = (o_Alu_Read == 2'b01) ? env_a :
                            (o_Alu_Read == 2'b10) ? env_f : 8'h00;
    assign i_Mem_Rdata    = o_Mem_Addr_Sel ? env_mem : env_d8;
    assign {alu_res_c, alu_flg_c} = alu_calc(o_Alu_Function_Control, o_Alu_Opcode, env_a,
                                             o_Alu_Parameter, env_f);
    assign i_Alu_Result   = alu_res_c;

    // Environment state commits strobes only when enabled, like the real ALU/regfile
    always @(posedge i_Clk) begin
        if (ld) begin
            env_a <= ld_a; env_f <= ld_f; env_mem <= ld_mem; env_d8 <= ld_d8;
            for (int i = 0; i < 8; i++) env_rf[i] <= ld_rf[i];
            wr_cnt <= 0;
        end else if (i_Enable) begin
            if (o_Alu_Write[0]) env_a <= o_Alu_Data;
            if (o_Alu_Write[1]) env_f <= o_Alu_Data;
            else if (o_Alu_Save_Flags) env_f <= alu_flg_c;
            if (o_Reg_We) env_rf[o_Reg_Sel] <= o_Reg_Wdata;
            if (o_Mem_Req && o_Mem_We && i_Mem_Ack) env_mem <= o_Mem_Wdata;
            wr_cnt <= wr_cnt + int'(o_Alu_Write[0]) + int'(o_Alu_Write[1]) + int'(o_Reg_We)
                      + int'(o_Mem_Req && o_Mem_We && i_Mem_Ack);
        end
    end

    // Called at a negedge; applies ld_* on the next posedge
    task automatic do_load();
        ld = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        ld = 1'b0;
    endtask

    task automatic rand_env();
        ld_a = 8'($urandom); ld_f = {4'($urandom), 4'h0};
        ld_mem = 8'($urandom); ld_d8 = 8'($urandom);
        for (int i = 0; i < 8; i++) ld_rf[i] = 8'($urandom);
    endtask

    // Issue one opcode and serve memory; returns observations (lat = -1 on timeout)
    task automatic run_op(input bit cb, input logic [7:0] op, input int rd_w, input int wr_w,
                          output int lat, output logic [5:0] ex_fc, output logic [7:0] ex_op,
                          output logic [7:0] ex_par, output int n_rd, output int n_wr,
                          output int rd_cyc, output bit hold_bad, output bit was_ready);
        int         cnt;
        logic [9:0] prev;
        bit         prev_v;
        lat = -1; ex_fc = '0; ex_op = '0; ex_par = '0;
        n_rd = 0; n_wr = 0; rd_cyc = 0; hold_bad = 1'b0;
        was_ready = o_Instr_Ready;
        i_Instr_Valid = 1'b1; i_Cb = cb; i_Opcode = op;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Instr_Valid = 1'b0;
        cnt = 0; prev_v = 1'b0; prev = '0;
        for (int c = 1; c <= 40; c++) begin
            if (o_Mem_Req) begin
                cnt++;
                if (prev_v && prev !== {o_Mem_We, o_Mem_Addr_Sel, o_Mem_Wdata}) hold_bad = 1'b1;
                prev = {o_Mem_We, o_Mem_Addr_Sel, o_Mem_Wdata}; prev_v = 1'b1;
                if (!o_Mem_We) rd_cyc++;
                i_Mem_Ack = (cnt >= (o_Mem_We ? wr_w : rd_w));
            end else begin
                i_Mem_Ack = 1'b0; cnt = 0; prev_v = 1'b0;
            end
            #1;
            if (o_Alu_Save_Flags) begin
                ex_fc = o_Alu_Function_Control; ex_op = o_Alu_Opcode; ex_par = o_Alu_Parameter;
            end
            if (o_Mem_Req && i_Mem_Ack) begin
                if (o_Mem_We) n_wr++; else n_rd++;
                cnt = 0; prev_v = 1'b0;
            end
            if (o_Done) lat = c;
            @(posedge i_Clk);
            @(negedge i_Clk);
            i_Mem_Ack = 1'b0;
            if (lat >= 0) break;
        end
    endtask

    int         lat, n_rd, n_wr, rd_cyc;
    logic [5:0] ex_fc;
    logic [7:0] ex_op, ex_par;
    bit         hold_bad, was_ready;

    task automatic test_reset();
        logic [59:0] v;
        i_Reset = 1'b1;
        @(negedge i_Clk);
        v = {o_Done, o_Illegal, o_Reg_Sel, o_Reg_We, o_Reg_Wdata, o_Mem_Req, o_Mem_We,
             o_Mem_Addr_Sel, o_Mem_Wdata, o_Alu_Read, o_Alu_Write, o_Alu_Data, o_Alu_Opcode,
             o_Alu_Parameter, o_Alu_Function_Control, o_Alu_Save_Flags};
        n_cmp++;
        if (o_Instr_Ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b exp 1", o_Instr_Ready);
        end
        n_cmp++;
        if (v !== 60'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h exp 0", v);
        end
        i_Reset = 1'b0;
        @(negedge i_Clk);
        n_cmp++;
        if (o_Instr_Ready !== 1'b1 || o_Mem_Req !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got rdy=%b req=%b exp 1/0",
                               o_Instr_Ready, o_Mem_Req);
        end
    endtask

    task automatic test_add_reg();
        rand_env(); ld_a = 8'h3A; ld_f = 8'h00; ld_rf[0] = 8'hC6; do_load();
        run_op(1'b0, 8'h80, 1, 1, lat, ex_fc, ex_op, ex_par, n_rd, n_wr, rd_cyc, hold_bad,
               was_ready);
        n_cmp++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d exp 1", lat); end
        n_cmp++;
        if (env_a !== 8'h00 || env_f !== 8'hB0) begin
            n_fail++; $display("FAIL add_a_f got A=%h F=%h exp A=00 F=b0", env_a, env_f);
        end
    endtask

    task automatic test_cp_d8();
        rand_env(); ld_a = 8'h3A; ld_f = 8'h00; ld_d8 = 8'h3A; ld_mem = 8'h11; do_load();
        run_op(1'b0, 8'hFE, 3, 1, lat, ex_fc, ex_op, ex_par, n_rd, n_wr, rd_cyc, hold_bad,
               was_ready);
        n_cmp++;
        if (rd_cyc !== 3 || lat !== 4) begin
            n_fail++; $display("FAIL cp_d8_timing got req=%0d lat=%0d exp 3/4", rd_cyc, lat);
        end
        n_cmp++;
        if (env_f !== 8'hC0 || env_a !== 8'h3A || wr_cnt !== 0) begin
            n_fail++; $display("FAIL cp_d8_result got F=%h A=%h wr=%0d exp c0/3a/0",
                               env_f, env_a, wr_cnt);
        end
    endtask

    task automatic test_dec_hl();
        rand_env(); ld_f = 8'h10; ld_mem = 8'h01; do_load();
        run_op(1'b0, 8'h35, 1, 2, lat, ex_fc, ex_op, ex_par, n_rd, n_wr, rd_cyc, hold_bad,
               was_ready);
        n_cmp++;
        if (env_mem !== 8'h00 || env_f !== 8'hD0) begin
            n_fail++; $display("FAIL dec_hl_result got M=%h F=%h exp 00/d0", env_mem, env_f);
        end
        n_cmp++;
        if (lat !== 4 || n_rd !== 1 || n_wr !== 1 || hold_bad) begin
            n_fail++; $display("FAIL dec_hl_bus got lat=%0d rd=%0d wr=%0d hold_bad=%0b exp 4/1/1/0",
                               lat, n_rd, n_wr, hold_bad);
        end
    endtask

    task automatic test_cb_bit();
        rand_env(); ld_f = 8'h00; ld_rf[4] = 8'h80; do_load();
        run_op(1'b1, 8'h7C, 1, 1, lat, ex_fc, ex_op, ex_par, n_rd, n_wr, rd_cyc, hold_bad,
               was_ready);
        n_cmp++;
        if (env_f !== 8'h20 || wr_cnt !== 0 || env_rf[4] !== 8'h80) begin
            n_fail++; $display("FAIL cb_bit got F=%h wr=%0d H=%h exp 20/0/80",
                               env_f, wr_cnt, env_rf[4]);
        end
        n_cmp++;
        if (lat !== 1 || ex_fc !== 6'b001000) begin
            n_fail++; $display("FAIL cb_bit_ctl got lat=%0d fc=%b exp 1/001000", lat, ex_fc);
        end
    endtask

    task automatic test_illegal();
        rand_env(); do_load();
        i_Instr_Valid = 1'b1; i_Cb = 1'b0; i_Opcode = 8'h00;
        #1;
        n_cmp++;
        if (o_Illegal !== 1'b1 || o_Mem_Req !== 1'b0 || o_Alu_Save_Flags !== 1'b0) begin
            n_fail++; $display("FAIL illegal_pulse got ill=%b req=%b save=%b exp 1/0/0",
                               o_Illegal, o_Mem_Req, o_Alu_Save_Flags);
        end
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Instr_Valid = 1'b0;
        #1;
        n_cmp++;
        if (o_Illegal !== 1'b0 || o_Instr_Ready !== 1'b1 || wr_cnt !== 0) begin
            n_fail++; $display("FAIL illegal_after got ill=%b rdy=%b wr=%0d exp 0/1/0",
                               o_Illegal, o_Instr_Ready, wr_cnt);
        end
        @(negedge i_Clk);
    endtask

    task automatic test_enable();
        rand_env(); ld_f = 8'h00; ld_rf[0] = 8'h0F; do_load();
        i_Instr_Valid = 1'b1; i_Cb = 1'b0; i_Opcode = 8'h04;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Instr_Valid = 1'b0;
        i_Enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_Clk);
            @(negedge i_Clk);
            n_cmp++;
            if (o_Done !== 1'b1 || o_Instr_Ready !== 1'b0 || wr_cnt !== 0) begin
                n_fail++; $display("FAIL enable_hold got done=%b rdy=%b wr=%0d exp 1/0/0",
                                   o_Done, o_Instr_Ready, wr_cnt);
            end
        end
        i_Enable = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        n_cmp++;
        if (o_Instr_Ready !== 1'b1 || env_rf[0] !== 8'h10 || env_f !== 8'h20) begin
            n_fail++; $display("FAIL enable_resume got rdy=%b B=%h F=%h exp 1/10/20",
                               o_Instr_Ready, env_rf[0], env_f);
        end
    endtask

    task automatic test_reset_mid_fetch();
        rand_env(); ld_a = 8'h12; ld_f = 8'h00; ld_rf[1] = 8'h05; do_load();
        i_Instr_Valid = 1'b1; i_Cb = 1'b0; i_Opcode = 8'h86;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Instr_Valid = 1'b0;
        @(posedge i_Clk);
        @(negedge i_Clk);
        n_cmp++;
        if (o_Mem_Req !== 1'b1) begin
            n_fail++; $display("FAIL fetch_pending got req=%b exp 1", o_Mem_Req);
        end
        i_Reset = 1'b1;
        #1;
        n_cmp++;
        if (o_Mem_Req !== 1'b0 || o_Instr_Ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid got req=%b rdy=%b exp 0/1", o_Mem_Req,
                               o_Instr_Ready);
        end
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        n_cmp++;
        if (wr_cnt !== 0 || env_a !== 8'h12) begin
            n_fail++; $display("FAIL reset_mid_writes got wr=%0d A=%h exp 0/12", wr_cnt, env_a);
        end
        run_op(1'b0, 8'h81, 1, 1, lat, ex_fc, ex_op, ex_par, n_rd, n_wr, rd_cyc, hold_bad,
               was_ready);
        n_cmp++;
        if (lat !== 1 || env_a !== 8'h17) begin
            n_fail++; $display("FAIL after_reset_op got lat=%0d A=%h exp 1/17", lat, env_a);
        end
    endtask

    // Random opcodes issued back to back against the rule-based reference
    task automatic test_random_back_to_back();
        bit         cb, legal;
        logic [7:0] op, par, res, nf, ea, ef, emem;
        logic [7:0] erf [8];
        logic [5:0] fc;
        int         src, dst, rdw, wrw, elat;
        for (int n = 0; n < 120; n++) begin
            do begin
                cb = ($urandom_range(0, 3) == 0);
                op = 8'($urandom);
                classify(cb, op, legal, fc, src, dst);
            end while (!legal);
            rdw = $urandom_range(1, 3);
            wrw = $urandom_range(1, 3);
            rand_env();
            do_load();
            par = (src == 8) ? ld_d8 : (src == 6) ? ld_mem : (src == 7) ? ld_a : ld_rf[src];
            {res, nf} = alu_calc(fc, op, ld_a, par, ld_f);
            ea = ld_a; ef = nf; emem = ld_mem; erf = ld_rf;
            if (dst == 7) ea = res;
            else if (dst == 6) emem = res;
            else if (dst >= 0) erf[dst] = res;
            elat = 1 + ((src == 8 || src == 6) ? rdw : 0) + ((dst == 6) ? wrw : 0);
            run_op(cb, op, rdw, wrw, lat, ex_fc, ex_op, ex_par, n_rd, n_wr, rd_cyc, hold_bad,
                   was_ready);
            n_cmp++;
            if (!was_ready || lat !== elat) begin
                n_fail++; $display("FAIL rnd_timing cb=%b op=%h got rdy=%b lat=%0d exp 1/%0d",
                                   cb, op, was_ready, lat, elat);
            end
            n_cmp++;
            if (ex_fc !== fc || ex_op !== op || ex_par !== par) begin
                n_fail++; $display("FAIL rnd_alu_ctl cb=%b op=%h got fc=%b op=%h p=%h exp %b/%h/%h",
                                   cb, op, ex_fc, ex_op, ex_par, fc, op, par);
            end
            n_cmp++;
            if (n_rd !== int'(src == 8 || src == 6) || n_wr !== int'(dst == 6) || hold_bad) begin
                n_fail++; $display("FAIL rnd_mem cb=%b op=%h got rd=%0d wr=%0d hold_bad=%0b",
                                   cb, op, n_rd, n_wr, hold_bad);
            end
            n_cmp++;
            if (env_a !== ea || env_f !== ef || env_mem !== emem) begin
                n_fail++; $display("FAIL rnd_state cb=%b op=%h got A=%h F=%h M=%h exp %h/%h/%h",
                                   cb, op, env_a, env_f, env_mem, ea, ef, emem);
            end
            for (int r = 0; r < 6; r++) begin
                n_cmp++;
                if (env_rf[r] !== erf[r]) begin
                    n_fail++; $display("FAIL rnd_reg%0d cb=%b op=%h got %h exp %h",
                                       r, cb, op, env_rf[r], erf[r]);
                end
            end
        end
    endtask

    initial begin
        i_Reset = 1'b1; i_Enable = 1'b1; i_Instr_Valid = 1'b0; i_Cb = 1'b0;
        i_Opcode = 8'h00; i_Mem_Ack = 1'b0;
        rand_env();
        test_reset();
        do_load();
        test_add_reg();
        test_cp_d8();
        test_dec_hl();
        test_cb_bit();
        test_illegal();
        test_enable();
        test_reset_mid_fetch();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
